// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the traffic-light sequencer.
//   state_t   : sequencer phases (S_WALK exists only in the PED_EN build's reachable set)
//   L_*       : 3-bit lamp group codes, {RED, GREEN, YELLOW}
//   lamp_of() : lamp group shown by the served channel in a given phase
package traffic_pkg;

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_FLASH  = 3'd3,
    S_WALK   = 3'd4
  } state_t;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_GREEN  = 3'b010;
  localparam logic [2:0] L_YELLOW = 3'b001;
  localparam logic [2:0] L_DARK   = 3'b000;

  function automatic logic [2:0] lamp_of(input state_t s);
    case (s)
      S_GREEN:  lamp_of = L_GREEN;
      S_YELLOW: lamp_of = L_YELLOW;
      default:  lamp_of = L_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_seq_dwell_timer.sv
// dwell_timer: loadable down-counter with terminal-count flag.
//   clock, reset : clock and async active-high reset (counter -> RST_VAL)
//   load, value  : synchronous load, takes priority over counting
//   enable       : decrement when nonzero
//   zero         : counter is at terminal count
module dwell_timer #(
  parameter int          CNT_W   = 16,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             enable,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= CNT_W'(RST_VAL);
    else if (load)
      cnt <= value;
    else if (enable && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_seq.sv
// traffic_seq: multi-approach traffic-light sequencer.
//   clock, reset  : rising-edge clock, async active-high reset
//   enable        : 1 = run, 0 = hold state, timers and outputs
//   flash_req     : level request for fault flash mode (overrides everything)
//   light         : 3 bits per channel, channel c at [3c+2:3c], {RED,GREEN,YELLOW}
//   active_ch     : channel currently served
//   phase_start   : one-cycle pulse in the first cycle of every GREEN
//   ped_req, walk : pedestrian request / walk lamp, present only when PED_EN is defined
// Build option: define PED_EN to add the pedestrian WALK phase.
module traffic_seq
  import traffic_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 16,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int CLEAR_T  = 2,
  parameter int FLASH_T  = 4,
  parameter int WALK_T   = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flash_req,
  output logic [3*NUM_CH-1:0]        light,
  output logic [$clog2(NUM_CH)-1:0]  active_ch,
  output logic                       phase_start
`ifdef PED_EN
  ,
  input  logic                       ped_req,
  output logic                       walk
`endif
);

  localparam int AW = $clog2(NUM_CH);

  state_t           state, state_nx;
  logic [AW-1:0]    ch_nx, ch_inc;
  logic             dw_zero, fl_zero, fl_load;
  logic             toggle, toggle_nx;
  logic             ped_go;
  logic [3*NUM_CH-1:0] light_nx;

  function automatic logic [CNT_W-1:0] dwell_len(input state_t s);
    case (s)
      S_CLEAR:  dwell_len = CNT_W'(CLEAR_T - 1);
      S_GREEN:  dwell_len = CNT_W'(GREEN_T - 1);
      S_YELLOW: dwell_len = CNT_W'(YELLOW_T - 1);
      S_WALK:   dwell_len = CNT_W'(WALK_T - 1);
      default:  dwell_len = '0;
    endcase
  endfunction

  assign ch_inc = (active_ch == AW'(NUM_CH - 1)) ? '0 : active_ch + 1'b1;

`ifdef PED_EN
  logic pend, pend_nx;
  // A request arriving on the very edge YELLOW expires still counts.
  assign ped_go = pend | ped_req;

  always_comb begin
    pend_nx = pend;
    if (state_nx == S_WALK && state != S_WALK)
      pend_nx = 1'b0;
    else if (ped_req && state != S_WALK)
      pend_nx = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
      walk <= 1'b0;
    end else begin
      pend <= pend_nx;
      walk <= (state_nx == S_WALK);
    end
  end
`else
  assign ped_go = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    ch_nx    = active_ch;
    if (flash_req) begin
      state_nx = S_FLASH;
    end else if (state == S_FLASH) begin
      state_nx = S_CLEAR;
      ch_nx    = '0;
    end else if (enable && dw_zero) begin
      case (state)
        S_CLEAR:  state_nx = S_GREEN;
        S_GREEN:  state_nx = S_YELLOW;
        S_YELLOW: begin
          if (ped_go) begin
            state_nx = S_WALK;
          end else begin
            state_nx = S_CLEAR;
            ch_nx    = ch_inc;
          end
        end
        S_WALK: begin
          state_nx = S_CLEAR;
          ch_nx    = ch_inc;
        end
        default:  state_nx = S_CLEAR;
      endcase
    end
  end

  // Toggle restarts dark on every FLASH entry so the pattern is deterministic.
  always_comb begin
    toggle_nx = toggle;
    fl_load   = 1'b0;
    if (state_nx == S_FLASH && state != S_FLASH) begin
      toggle_nx = 1'b0;
      fl_load   = 1'b1;
    end else if (state_nx == S_FLASH && enable && fl_zero) begin
      toggle_nx = ~toggle;
      fl_load   = 1'b1;
    end
  end

  always_comb begin
    light_nx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (state_nx == S_FLASH)
        light_nx[3*c +: 3] = toggle_nx ? L_YELLOW : L_DARK;
      else if (ch_nx == AW'(c))
        light_nx[3*c +: 3] = lamp_of(state_nx);
      else
        light_nx[3*c +: 3] = L_RED;
    end
  end

  dwell_timer #(.CNT_W(CNT_W), .RST_VAL(CLEAR_T - 1)) u_dwell (
    .clock  (clock),
    .reset  (reset),
    .load   (state_nx != state),
    .value  (dwell_len(state_nx)),
    .enable (enable),
    .zero   (dw_zero)
  );

  dwell_timer #(.CNT_W(CNT_W), .RST_VAL(FLASH_T - 1)) u_flash (
    .clock  (clock),
    .reset  (reset),
    .load   (fl_load),
    .value  (CNT_W'(FLASH_T - 1)),
    .enable (enable && state == S_FLASH),
    .zero   (fl_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_CLEAR;
      active_ch   <= '0;
      toggle      <= 1'b0;
      light       <= {NUM_CH{L_RED}};
      phase_start <= 1'b0;
    end else begin
      state       <= state_nx;
      active_ch   <= ch_nx;
      toggle      <= toggle_nx;
      light       <= light_nx;
      phase_start <= (state_nx == S_GREEN && state != S_GREEN);
    end
  end

endmodule

// File: tb/tb_traffic_seq.sv
module tb_traffic_seq;

  localparam int NUM_CH   = 2;
  localparam int GREEN_T  = 4;
  localparam int YELLOW_T = 2;
  localparam int CLEAR_T  = 1;
  localparam int FLASH_T  = 2;
  localparam int WALK_T   = 3;
`ifdef PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  // model phase codes (independent of RTL encoding)
  localparam int P_CLR = 10, P_GRN = 11, P_YEL = 12, P_FL = 13, P_WLK = 14;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic                flash_req = 1'b0;
  logic                ped = 1'b0;
  logic [3*NUM_CH-1:0] light;
  logic [0:0]          active_ch;
  logic                phase_start;
`ifdef PED_EN
  logic                walk;
`endif

  traffic_seq #(
    .NUM_CH(NUM_CH), .CNT_W(16), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T),
    .CLEAR_T(CLEAR_T), .FLASH_T(FLASH_T), .WALK_T(WALK_T)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .flash_req   (flash_req),
    .light       (light),
    .active_ch   (active_ch),
    .phase_start (phase_start)
`ifdef PED_EN
    ,
    .ped_req     (ped),
    .walk        (walk)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // reference model: phase, enabled cycles elapsed in phase, served channel
  int m_ph, m_age, m_ch, m_pend, m_flage, m_tog, m_ps;

  function automatic int dur(input int ph);
    case (ph)
      P_CLR:   return CLEAR_T;
      P_GRN:   return GREEN_T;
      P_YEL:   return YELLOW_T;
      P_WLK:   return WALK_T;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = P_CLR; m_age = 0; m_ch = 0; m_pend = 0;
    m_flage = 0; m_tog = 0; m_ps = 0;
  endtask

  task automatic model_step();
    int was_walk, entered_walk;
    was_walk = (m_ph == P_WLK);
    entered_walk = 0;
    m_ps = 0;
    if (flash_req) begin
      if (m_ph != P_FL) begin
        m_ph = P_FL; m_tog = 0; m_flage = 0;
      end else if (enable) begin
        m_flage++;
        if (m_flage == FLASH_T) begin
          m_tog = 1 - m_tog; m_flage = 0;
        end
      end
    end else if (m_ph == P_FL) begin
      m_ph = P_CLR; m_age = 0; m_ch = 0;
    end else if (enable) begin
      m_age++;
      if (m_age == dur(m_ph)) begin
        m_age = 0;
        if (m_ph == P_CLR) begin
          m_ph = P_GRN; m_ps = 1;
        end else if (m_ph == P_GRN) begin
          m_ph = P_YEL;
        end else if (m_ph == P_YEL && PED && (m_pend || ped)) begin
          m_ph = P_WLK; entered_walk = 1;
        end else begin
          m_ph = P_CLR; m_ch = (m_ch + 1) % NUM_CH;
        end
      end
    end
    if (PED) begin
      if (entered_walk) m_pend = 0;
      else if (ped && !was_walk) m_pend = 1;
    end
  endtask

  function automatic logic [3*NUM_CH-1:0] exp_light();
    logic [3*NUM_CH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_ph == P_FL)                     v[3*c +: 3] = m_tog ? 3'b001 : 3'b000;
      else if (c == m_ch && m_ph == P_GRN)  v[3*c +: 3] = 3'b010;
      else if (c == m_ch && m_ph == P_YEL)  v[3*c +: 3] = 3'b001;
      else                                  v[3*c +: 3] = 3'b100;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("light", 32'(light), 32'(exp_light()));
    chk("active_ch", 32'(active_ch), 32'(m_ch));
    chk("phase_start", 32'(phase_start), 32'(m_ps));
`ifdef PED_EN
    chk("walk", 32'(walk), 32'(m_ph == P_WLK));
`endif
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_until(input int ph, input int ch, input bit last);
    int hit;
    hit = 0;
    for (int i = 0; i < 80 && !hit; i++) begin
      if (m_ph == ph && m_ch == ch && (!last || m_age == dur(ph) - 1)) hit = 1;
      else cyc();
    end
    if (m_ph == ph && m_ch == ch && (!last || m_age == dur(ph) - 1)) hit = 1;
    chk("reach_phase_timeout", 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl_hold;
    model_reset();
    #12;
    check_all();
    chk("reset_light", 32'(light), 32'h24);

    // normal run from reset release
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      cyc();
      if (i == 1) begin
        chk("cyc1_light", 32'(light), 32'b100_010);
        chk("cyc1_phase_start", 32'(phase_start), 32'd1);
      end
      if (i == 7) chk("cyc7_all_red", 32'(light), 32'b100_100);
      if (i == 8) begin
        chk("cyc8_light", 32'(light), 32'b010_100);
        chk("cyc8_phase_start", 32'(phase_start), 32'd1);
      end
    end

    // hold mid-GREEN
    cyc();
    enable = 1'b0;
    run(5);
    chk("hold_light", 32'(light), 32'b100_010);
    enable = 1'b1;
    run(6);

    // flash during ch1 GREEN
    run_until(P_GRN, 1, 1'b0);
    flash_req = 1'b1;
    cyc();
    chk("flash_entry_dark", 32'(light), 32'b000_000);
    run(8);
    flash_req = 1'b0;
    cyc();
    chk("flash_exit_red", 32'(light), 32'b100_100);
    cyc();
    chk("flash_exit_ch0_green", 32'(light), 32'b100_010);
    run(3);

    // async reset mid-YELLOW of ch1
    run_until(P_YEL, 1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_reset_light", 32'(light), 32'b100_100);
    @(negedge clock);
    reset = 1'b0;

`ifdef PED_EN
    // request on the last YELLOW cycle is honoured
    run_until(P_YEL, 0, 1'b1);
    ped = 1'b1;
    cyc();
    ped = 1'b0;
    chk("ped_last_yellow_walk", 32'(walk), 32'd1);
    run(6);
    // request pulse during ch0 GREEN
    run_until(P_GRN, 0, 1'b0);
    ped = 1'b1;
    cyc();
    ped = 1'b0;
    run(12);
`endif

    // randomized traffic
    fl_hold = 0;
    for (int i = 0; i < 800; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      ped = PED && ($urandom_range(0, 19) == 0);
      if (fl_hold > 0) fl_hold--;
      else if ($urandom_range(0, 59) == 0) fl_hold = $urandom_range(2, 12);
      flash_req = (fl_hold > 0);
      cyc();
    end
    flash_req = 1'b0;
    ped = 1'b0;
    enable = 1'b1;
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_seq.md
# traffic_seq

Parametrised multi-approach traffic-light sequencer. It cycles a configurable number of channels through GREEN, YELLOW and all-red clearance, with programmable dwell times per phase. It adds run/hold control and a fault flash mode, and optionally a pedestrian walk phase. It sits in the lamp/signal control area and drives per-channel 3-bit lamp groups directly.

## Interface
Parameters:
- NUM_CH, 2: number of approaches, 2..8.
- CNT_W, 16: dwell counter width.
- GREEN_T, 8: GREEN dwell in cycles, ≥1.
- YELLOW_T, 3: YELLOW dwell in cycles, ≥1.
- CLEAR_T, 2: all-red clearance dwell in cycles, ≥1.
- FLASH_T, 4: half-period of flash toggle in cycles, ≥1.
- WALK_T, 6: walk dwell in cycles, ≥1. Used only with PED_EN.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  1 = run; 0 = hold state and counter.
- flash_req  in  1  fault/flash mode request, level.
- light  out  3*NUM_CH  channel c at [3c+2:3c]; bit2 = RED, bit1 = GREEN, bit0 = YELLOW; exactly one bit set per channel except in FLASH.
- active_ch  out  $clog2(NUM_CH)  channel currently served.
- phase_start  out  1  one-cycle pulse on the edge entering any GREEN.
- ped_req  in  1  PED_EN only: pedestrian request pulse/level.
- walk  out  1  PED_EN only: walk lamp.

## Operation
- States: CLEAR, GREEN, YELLOW, FLASH, and WALK (PED_EN only).
- Outputs are registered and update on the same edge as the state.
- Dwell counter:
  - Loaded with T-1 on state entry.
  - Decrements each enabled cycle.
  - The transition fires on the enabled edge where the counter is 0, so a phase lasts exactly T enabled cycles.
- State transitions:
  - CLEAR → GREEN(active_ch).
  - GREEN → YELLOW.
  - YELLOW → CLEAR, with active_ch advanced (wrap NUM_CH-1 → 0).
  - With PED_EN and a pending request: YELLOW → WALK instead. WALK → CLEAR with active_ch advanced.
- Lamp outputs per state:
  - GREEN/YELLOW: the active channel shows GREEN/YELLOW; all others RED.
  - CLEAR: all RED.
  - WALK: all RED, walk=1.
- Reset value:
  - State CLEAR, active_ch=0, counter=CLEAR_T-1.
  - light = all RED (3'b100 per channel).
  - phase_start=0, walk=0, flash toggle=0, ped pending=0.
- enable=0:
  - State, counter, active_ch and flash toggle hold.
  - Outputs hold.
  - phase_start forced 0.
- flash_req=1, from any state:
  - The next edge enters FLASH, regardless of enable or counter.
  - FLASH: toggle register flips every FLASH_T enabled cycles. Toggle=1 sets all channels to YELLOW (3'b001); toggle=0 sets all channels dark (3'b000). walk=0.
- flash_req deasserted while in FLASH:
  - The next edge enters CLEAR with counter CLEAR_T-1 and active_ch=0.
  - The pending ped request is preserved.
- Simultaneous events:
  - flash_req beats all transitions.
  - A ped_req arriving in the same cycle YELLOW expires is honoured, and WALK is entered.
  - A ped_req during WALK is ignored. The pending flag clears on WALK entry.
- Reset mid-phase returns to the reset values immediately (asynchronously).

## Timing
- Full cycle without ped/flash: NUM_CH*(GREEN_T+YELLOW_T+CLEAR_T) cycles.
- ped_req latency: latched on the edge it is high; it takes effect at the end of the current/next YELLOW.
- phase_start is high during the first cycle of each GREEN.

## Configuration
- PED_EN defined:
  - ped_req and walk ports exist.
  - A ped pending flag and the WALK state are included.
- PED_EN undefined:
  - Ports, flag and WALK state are removed.
  - YELLOW always goes to CLEAR.
  - Behaviour is otherwise identical.

## Structure
- Package traffic_pkg holds:
  - State enum: CLEAR, GREEN, YELLOW, FLASH, WALK.
  - Lamp constants: RED=3'b100, GREEN=3'b010, YELLOW=3'b001, DARK=3'b000.
- Sub-module dwell_timer:
  - Inputs: load, load value, enable.
  - Outputs: zero flag.
  - Width CNT_W.
  - Used by both the dwell counter and the flash toggle (two instances).

## Test plan
Parameters for all scenarios: NUM_CH=2, GREEN_T=4, YELLOW_T=2, CLEAR_T=1, FLASH_T=2, WALK_T=3.
- Reset release, enable=1:
  - Cycle 1: light=100_010.
  - Cycles 1–4: ch0 GREEN.
  - Cycles 5–6: ch0 YELLOW.
  - Cycle 7: all RED.
  - Cycle 8: ch1 GREEN.
  - Period is 14 cycles.
  - phase_start pulses at cycles 1 and 8.
- enable=0 for 5 cycles mid-GREEN: light and active_ch are frozen, and GREEN resumes for its remaining cycles (total 4 enabled cycles).
- flash_req=1 during ch1 GREEN:
  - The next edge gives light=000_000, then 001_001 / 000_000 alternating every 2 cycles.
  - Deassert: 1 cycle all RED, then ch0 GREEN.
- PED_EN, ped_req pulse during ch0 GREEN: after ch0 YELLOW, 3 cycles all RED with walk=1, then 1 cycle CLEAR, then ch1 GREEN.
- Asynchronous reset asserted mid-YELLOW: light becomes all RED immediately without a clock edge, and active_ch=0.
- ped_req coincident with the last YELLOW cycle: WALK is entered.
